// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-side bus target: transfer modes and FSM states.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        MODE_READ        = 2'b00,
        MODE_WRITE       = 2'b01,
        MODE_BURST_READ  = 2'b10,
        MODE_BURST_WRITE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANTED = 2'b01,
        S_WAIT    = 2'b10,
        S_BEAT    = 2'b11
    } state_e;

    // Bit 0 of the mode selects write, bit 1 selects burst.
    function automatic logic mode_is_write(input mode_e m);
        return m[0];
    endfunction

    function automatic logic mode_is_burst(input mode_e m);
        return m[1];
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Single-port synchronous RAM with write enable and registered read port.
// The array itself is never reset; only the read register is.
module mem_bus_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds its value whenever no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_target.sv
// Memory-side target for the req/gnt/start/rdy bus with wait states and
// wrapping fixed-length bursts.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   S_IDLE    | bus not owned, gnt=0
//   S_GRANTED | gnt=1, waiting for start (or req drop)
//   S_WAIT    | wait-state countdown before the next beat
//   S_BEAT    | rdy=1 for one cycle; read data valid / write committed
module mem_bus_target
    import mem_bus_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              rdy
);

    localparam state_e     FIRST_STATE = (WAIT_STATES == 0) ? S_BEAT : S_WAIT;
    localparam logic [3:0] WAIT_INIT   = 4'(WAIT_STATES);
    localparam logic [4:0] BURST_INIT  = 5'(BURST_LEN);

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [4:0]        beats_q;
    logic [3:0]        wcnt_q;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic              start_ok;

    assign start_ok = (state_q == S_GRANTED) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and RAM control. Reads are issued on the edge that enters
    // S_BEAT so the registered RAM output is valid exactly while rdy is high.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = cur_addr_q;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_GRANTED;
            end
            S_GRANTED: begin
                if (start) begin
                    state_d = FIRST_STATE;
                    if ((WAIT_STATES == 0) && !mode_is_write(mode_e'(mode))) begin
                        ram_re   = 1'b1;
                        ram_addr = addr;
                    end
                end else if (!req) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd1) begin
                    state_d = S_BEAT;
                    ram_re  = !mode_is_write(mode_q);
                end
            end
            S_BEAT: begin
                ram_we = mode_is_write(mode_q);
                if (beats_q > 5'd1) begin
                    state_d = FIRST_STATE;
                    if ((WAIT_STATES == 0) && !mode_is_write(mode_q)) begin
                        ram_re   = 1'b1;
                        ram_addr = cur_addr_q + 1'b1;
                    end
                end else begin
                    state_d = req ? S_GRANTED : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction context: latched mode/address, beat and wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_READ;
            cur_addr_q <= '0;
            beats_q    <= '0;
            wcnt_q     <= '0;
        end else if (start_ok) begin
            mode_q     <= mode_e'(mode);
            cur_addr_q <= addr;
            beats_q    <= mode_is_burst(mode_e'(mode)) ? BURST_INIT : 5'd1;
            wcnt_q     <= WAIT_INIT;
        end else if (state_q == S_WAIT) begin
            wcnt_q <= wcnt_q - 4'd1;
        end else if (state_q == S_BEAT) begin
            beats_q    <= beats_q - 5'd1;
            cur_addr_q <= cur_addr_q + 1'b1;
            wcnt_q     <= WAIT_INIT;
        end
    end

    assign gnt = (state_q != S_IDLE);
    assign rdy = (state_q == S_BEAT);

    mem_bus_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(wdata),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_mem_bus_target.sv
// Directed bench: dut0 uses default wait states, dut1 runs with zero.
// Both share start/mode/addr/wdata; each has its own req so only one is active.
module tb_mem_bus_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata0, rdata1;
    logic       gnt0, gnt1, rdy0, rdy1;

    int checks = 0;
    int passed = 0;

    int         got;
    int         rdy_cyc [16];
    logic [7:0] rd_val  [16];
    logic [7:0] wr_data [16];

    always #5 clk = ~clk;

    mem_bus_target dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .start(start), .mode(mode),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .gnt(gnt0), .rdy(rdy0)
    );

    mem_bus_target #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .start(start), .mode(mode),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .gnt(gnt1), .rdy(rdy1)
    );

    // Launch one transaction from a GRANTED cycle and record each rdy beat:
    // cycle number after the start edge, read data, and feed write data.
    task automatic run_txn(input bit sel, input logic [1:0] m, input logic [7:0] a, input int nb);
        int n;
        logic r;
        n = 0;
        got = 0;
        start = 1'b1; mode = m; addr = a;
        while (got < nb && n < 100) begin
            @(posedge clk); #1;
            start = 1'b0; mode = ~m; addr = ~a;
            n++;
            r = sel ? rdy1 : rdy0;
            if (r) begin
                rdy_cyc[got] = n;
                rd_val[got]  = sel ? rdata1 : rdata0;
                wdata        = wr_data[got];
                got++;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (gnt0 !== 1'b0) $display("FAIL reset_gnt: got %b want 0", gnt0); else passed++;
        checks++; if (rdy0 !== 1'b0) $display("FAIL reset_rdy: got %b want 0", rdy0); else passed++;
        checks++; if (rdata0 !== 8'h00) $display("FAIL reset_rdata: got %h want 00", rdata0); else passed++;
        checks++; if (gnt1 !== 1'b0) $display("FAIL reset_gnt1: got %b want 0", gnt1); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        req0 = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt0 !== 1'b1) $display("FAIL t1_gnt: got %b want 1", gnt0); else passed++;
        wr_data[0] = 8'hA5;
        run_txn(0, 2'b01, 8'h10, 1);
        checks++; if (got !== 1 || rdy_cyc[0] !== 2) $display("FAIL t1_wr_latency: got %0d beats at %0d want 1 at 2", got, rdy_cyc[0]); else passed++;
        @(posedge clk); #1;
        checks++; if (rdy0 !== 1'b0 || gnt0 !== 1'b1) $display("FAIL t1_after_wr: got rdy=%b gnt=%b want 0/1", rdy0, gnt0); else passed++;
        run_txn(0, 2'b00, 8'h10, 1);
        checks++; if (got !== 1 || rdy_cyc[0] !== 2) $display("FAIL t1_rd_latency: got %0d beats at %0d want 1 at 2", got, rdy_cyc[0]); else passed++;
        checks++; if (rd_val[0] !== 8'hA5) $display("FAIL t1_rdata: got %h want a5", rd_val[0]); else passed++;
        @(posedge clk); #1;
        checks++; if (rdy0 !== 1'b0) $display("FAIL t1_rdy_pulse: got %b want 0", rdy0); else passed++;
        checks++; if (rdata0 !== 8'hA5) $display("FAIL t1_rdata_hold: got %h want a5", rdata0); else passed++;
    endtask

    task automatic test_burst_wrap();
        for (int k = 0; k < 4; k++) wr_data[k] = 8'(k + 1);
        run_txn(0, 2'b11, 8'hFE, 4);
        checks++; if (got !== 4) $display("FAIL t2_wr_beats: got %0d want 4", got); else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy_cyc[k] !== 2 + 2 * k) $display("FAIL t2_wr_spacing[%0d]: got %0d want %0d", k, rdy_cyc[k], 2 + 2 * k);
            else passed++;
        end
        @(posedge clk); #1;
        run_txn(0, 2'b10, 8'hFE, 4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd_val[k] !== 8'(k + 1)) $display("FAIL t2_rd_data[%0d]: got %h want %h", k, rd_val[k], 8'(k + 1));
            else passed++;
        end
        @(posedge clk); #1;
        run_txn(0, 2'b00, 8'h00, 1);
        checks++; if (rd_val[0] !== 8'h03) $display("FAIL t2_wrap_word: got %h want 03", rd_val[0]); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        run_txn(0, 2'b00, 8'h10, 1);
        checks++; if (rd_val[0] !== 8'hA5) $display("FAIL t6_first: got %h want a5", rd_val[0]); else passed++;
        @(posedge clk); #1;
        checks++; if (gnt0 !== 1'b1 || rdy0 !== 1'b0) $display("FAIL t6_gap: got gnt=%b rdy=%b want 1/0", gnt0, rdy0); else passed++;
        run_txn(0, 2'b00, 8'hFF, 1);
        checks++; if (got !== 1 || rdy_cyc[0] !== 2) $display("FAIL t6_second_latency: got %0d beats at %0d want 1 at 2", got, rdy_cyc[0]); else passed++;
        checks++; if (rd_val[0] !== 8'h02) $display("FAIL t6_second_data: got %h want 02", rd_val[0]); else passed++;
        req0 = 1'b0;
        @(posedge clk); #1;
        checks++; if (gnt0 !== 1'b0) $display("FAIL t6_release: got %b want 0", gnt0); else passed++;
    endtask

    task automatic test_start_idle();
        bit seen;
        seen = 1'b0;
        start = 1'b1; mode = 2'b01; addr = 8'h10; wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rdy0 || gnt0) seen = 1'b1;
        end
        start = 1'b0;
        checks++; if (seen !== 1'b0) $display("FAIL t4_idle_start: got activity=%b want 0", seen); else passed++;
        req0 = 1'b1;
        checks++; if (gnt0 !== 1'b0) $display("FAIL t4_gnt_before: got %b want 0", gnt0); else passed++;
        @(posedge clk); #1;
        checks++; if (gnt0 !== 1'b1) $display("FAIL t4_gnt_after: got %b want 1", gnt0); else passed++;
        run_txn(0, 2'b00, 8'h10, 1);
        checks++; if (rd_val[0] !== 8'hA5) $display("FAIL t4_ram_unchanged: got %h want a5", rd_val[0]); else passed++;
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        req1 = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt1 !== 1'b1) $display("FAIL t3_gnt: got %b want 1", gnt1); else passed++;
        for (int k = 0; k < 4; k++) wr_data[k] = 8'(k + 1);
        run_txn(1, 2'b11, 8'hFE, 4);
        checks++; if (got !== 4) $display("FAIL t3_wr_beats: got %0d want 4", got); else passed++;
        @(posedge clk); #1;
        run_txn(1, 2'b10, 8'hFE, 4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy_cyc[k] !== k + 1) $display("FAIL t3_rd_cycle[%0d]: got %0d want %0d", k, rdy_cyc[k], k + 1);
            else passed++;
            checks++;
            if (rd_val[k] !== 8'(k + 1)) $display("FAIL t3_rd_data[%0d]: got %h want %h", k, rd_val[k], 8'(k + 1));
            else passed++;
        end
        req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int n;
        req0 = 1'b1;
        @(posedge clk); #1;
        wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_data[2] = 8'h33; wr_data[3] = 8'h44;
        run_txn(0, 2'b11, 8'h20, 4);
        @(posedge clk); #1;
        wr_data[0] = 8'hA1; wr_data[1] = 8'hA2; wr_data[2] = 8'hA3; wr_data[3] = 8'hA4;
        start = 1'b1; mode = 2'b11; addr = 8'h20;
        n = 0; got = 0;
        while (got < 2 && n < 100) begin
            @(posedge clk); #1;
            start = 1'b0; n++;
            if (rdy0) begin
                wdata = wr_data[got];
                got++;
            end
        end
        checks++; if (got !== 2) $display("FAIL t5_reached_beat2: got %0d want 2", got); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt0 !== 1'b0 || rdy0 !== 1'b0) $display("FAIL t5_abort: got gnt=%b rdy=%b want 0/0", gnt0, rdy0); else passed++;
        checks++; if (rdata0 !== 8'h00) $display("FAIL t5_rdata_reset: got %h want 00", rdata0); else passed++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 2'b10, 8'h20, 4);
        checks++; if (rd_val[0] !== 8'hA1) $display("FAIL t5_word1: got %h want a1", rd_val[0]); else passed++;
        checks++; if (rd_val[2] !== 8'h33) $display("FAIL t5_word3: got %h want 33", rd_val[2]); else passed++;
        checks++; if (rd_val[3] !== 8'h44) $display("FAIL t5_word4: got %h want 44", rd_val[3]); else passed++;
        req0 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_back_to_back();
        test_start_idle();
        test_zero_wait();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
